// File: rtl/move_scheduler.sv
// Button-to-engine move scheduler: priority arbitration, move FIFO, one-at-a-time issue.
// Optional HOLDOFF_EN macro adds a minimum gap (HOLDOFF_CYCLES) after each move_done.
module move_scheduler #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int CNT_W          = 3,
  parameter int HOLDOFF_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_new,
  output logic             move_valid,
  output logic [1:0]       move_dir,
  input  logic             move_ready,
  input  logic             move_done,
  output logic             newgame_req,
  input  logic             newgame_ack,
  output logic [CNT_W-1:0] q_count,
  output logic             overflow,
  output logic             busy
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEW
`ifdef HOLDOFF_EN
    , S_HOLD
`endif
  } state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_dir;
  logic             r_new_pending, r_overflow;

  logic [3:0] w_btn;
  logic [1:0] w_win_dir;
  logic       w_any, w_multi, w_full, w_pop, w_flush, w_ignore, w_push, w_drop, w_hold_done;

  assign w_btn   = {btn_up, btn_down, btn_left, btn_right};
  assign w_any   = |w_btn;
  assign w_multi = (w_btn & (w_btn - 4'd1)) != 4'd0;
  assign w_full  = (r_count == CNT_W'(QUEUE_DEPTH));
  assign w_pop   = (r_state == S_ISSUE) && move_ready;
  assign w_flush = (r_state == S_IDLE) && r_new_pending;
  // Pulses arriving while a new game starts are discarded silently, not counted as overflow.
  assign w_ignore = (r_state == S_NEW) || w_flush;
  assign w_push   = w_any && !w_ignore && (!w_full || w_pop);
  assign w_drop   = w_any && !w_ignore && (w_multi || (w_full && !w_pop));

  always_comb begin
    w_win_dir = 2'b11;
    if (btn_up)        w_win_dir = 2'b00;
    else if (btn_down) w_win_dir = 2'b01;
    else if (btn_left) w_win_dir = 2'b10;
  end

`ifdef HOLDOFF_EN
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
  logic [HOLD_W-1:0] r_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_hold <= '0;
    else if (r_state != S_HOLD) r_hold <= '0;
    else                        r_hold <= r_hold + HOLD_W'(1);
  end

  assign w_hold_done = (r_hold == HOLD_W'(HOLDOFF_CYCLES - 1));
`else
  logic w_unused_holdoff;
  assign w_unused_holdoff = |HOLDOFF_CYCLES;
  assign w_hold_done      = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_new_pending)         w_next = S_NEW;
        else if (r_count != '0)    w_next = S_ISSUE;
      end
      S_ISSUE: if (move_ready)     w_next = S_WAIT;
      S_WAIT: begin
`ifdef HOLDOFF_EN
        if (move_done)             w_next = S_HOLD;
`else
        if (move_done)             w_next = S_IDLE;
`endif
      end
`ifdef HOLDOFF_EN
      S_HOLD: if (r_new_pending || w_hold_done) w_next = S_IDLE;
`endif
      S_NEW: if (newgame_ack)      w_next = S_IDLE;
      default:                     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_win_dir;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_dir         <= '0;
      r_new_pending <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      // A fresh btn_new in the flush cycle stays pending so it is not lost.
      if (btn_new)      r_new_pending <= 1'b1;
      else if (w_flush) r_new_pending <= 1'b0;
      if ((r_state == S_IDLE) && (w_next == S_ISSUE)) r_dir <= r_mem[r_rd_ptr];
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  assign move_valid  = (r_state == S_ISSUE);
  assign move_dir    = r_dir;
  assign newgame_req = (r_state == S_NEW);
  assign busy        = (r_state != S_IDLE);
  assign q_count     = r_count;
  assign overflow    = r_overflow;

endmodule
